// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: a signed fixed-point dot product of N_IN inputs and
// weights is accumulated with P multipliers over N_IN/P beats. The accumulator
// then feeds either a saturating linear output or an external synchronous
// sigmoid ROM. Valid/ready handshakes on both sides let layers be chained.
module neuron_mac_seq #(
    parameter int N_IN      = 8,
    parameter int P         = 2,
    parameter int DW        = 17,
    parameter int FRAC      = 15,
    parameter int LUT_AW    = 11,
    parameter int LUT_SHIFT = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*DW-1:0]     x,
    input  logic [N_IN*DW-1:0]     w,
    input  logic                   mode,
    output logic [LUT_AW-1:0]      lut_a,
    input  logic [DW-1:0]          lut_q,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [DW-1:0]          y,
    output logic                   y_sat
);

    localparam int B     = N_IN / P;
    localparam int BW    = (B > 1) ? $clog2(B) : 1;
    localparam int ACC_W = 2*DW - FRAC + $clog2(N_IN) + 1;

    // Clamp bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] A_MAX = {{(ACC_W-LUT_AW+1){1'b0}}, {(LUT_AW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] A_MIN = {{(ACC_W-LUT_AW+1){1'b1}}, {(LUT_AW-1){1'b0}}};
    localparam logic [LUT_AW-1:0]       LUT_MID = {1'b1, {(LUT_AW-1){1'b0}}};

    if ((N_IN % P) != 0) begin : g_bad_lanes
        $error("neuron_mac_seq: N_IN must be a multiple of P");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_LADDR,
        S_LWAIT,
        S_OUT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [N_IN*DW-1:0]        x_r;
    logic [N_IN*DW-1:0]        w_r;
    logic                      mode_r;
    logic signed [ACC_W-1:0]   acc;
    logic [BW-1:0]             beat;

    logic signed [ACC_W-1:0]   psum [P+1];
    logic signed [ACC_W-1:0]   acc_shift;
    logic [DW-1:0]             y_lin;
    logic                      lin_sat;
    logic [LUT_AW-1:0]         lut_s;
    logic                      lut_clamp;

    assign in_ready = (state == S_IDLE);

    // Operands are shifted down by P lanes every beat, so the multipliers always
    // read the lowest P lanes and need no beat-indexed lane selection.
    assign psum[0] = '0;
    for (genvar j = 0; j < P; j++) begin : g_lane
        logic signed [DW-1:0]     xs;
        logic signed [DW-1:0]     ws;
        logic signed [2*DW-1:0]   prod;
        assign xs          = x_r[j*DW +: DW];
        assign ws          = w_r[j*DW +: DW];
        assign prod        = xs * ws;
        assign psum[j+1]   = psum[j] + ACC_W'(prod >>> FRAC);
    end

    // Saturation of the accumulator for both output paths.
    always_comb begin
        y_lin     = acc[DW-1:0];
        lin_sat   = 1'b0;
        acc_shift = acc >>> LUT_SHIFT;
        lut_s     = acc_shift[LUT_AW-1:0];
        lut_clamp = 1'b0;
        if (acc > Y_MAX) begin
            y_lin   = Y_MAX[DW-1:0];
            lin_sat = 1'b1;
        end else if (acc < Y_MIN) begin
            y_lin   = Y_MIN[DW-1:0];
            lin_sat = 1'b1;
        end
        if (acc_shift > A_MAX) begin
            lut_s     = A_MAX[LUT_AW-1:0];
            lut_clamp = 1'b1;
        end else if (acc_shift < A_MIN) begin
            lut_s     = A_MIN[LUT_AW-1:0];
            lut_clamp = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_MAC;
            S_MAC:   if (beat == '0) state_next = mode_r ? S_LADDR : S_OUT;
            S_LADDR: state_next = S_LWAIT;
            S_LWAIT: state_next = S_OUT;
            S_OUT:   if (y_valid && y_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, accumulation, ROM address and result registers.
    // The first OUT cycle (y_valid still low) loads y; this gives the linear path
    // its extra register stage and lets the ROM data settle for the sigmoid path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            w_r     <= '0;
            mode_r  <= 1'b0;
            acc     <= '0;
            beat    <= '0;
            lut_a   <= LUT_MID;
            y       <= '0;
            y_valid <= 1'b0;
            y_sat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_r    <= x;
                        w_r    <= w;
                        mode_r <= mode;
                        acc    <= '0;
                        beat   <= BW'(B - 1);
                    end
                end
                S_MAC: begin
                    acc  <= acc + psum[P];
                    x_r  <= x_r >> (P*DW);
                    w_r  <= w_r >> (P*DW);
                    beat <= beat - BW'(1);
                end
                S_LADDR: begin
                    lut_a <= lut_s + LUT_MID;
                    y_sat <= lut_clamp;
                end
                S_OUT: begin
                    if (!y_valid) begin
                        y_valid <= 1'b1;
                        y       <= mode_r ? lut_q : y_lin;
                        if (!mode_r) begin
                            y_sat <= lin_sat;
                        end
                    end else if (y_ready) begin
                        y_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: directed vectors on the default
// configuration plus reference-model vectors on two other lane configurations.
module tb_neuron_mac_seq;

    localparam int DW     = 17;
    localparam int N_IN   = 8;
    localparam int P      = 2;
    localparam int LUT_AW = 11;

    typedef struct {
        int y;
        int sat;
        int addr;
        int lat;
        int acc_cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_IN*DW-1:0]    x = '0;
    logic [N_IN*DW-1:0]    w = '0;
    logic                  mode = 1'b0;
    logic [LUT_AW-1:0]     lut_a;
    logic [DW-1:0]         lut_q;
    logic                  y_valid;
    logic                  y_ready = 1'b1;
    logic [DW-1:0]         y;
    logic                  y_sat;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   sweep_go = 1'b0;
    int   xa[8];
    int   wa[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // ROM model: data = address + 7, one clock of latency.
    always @(posedge clk) lut_q <= DW'(lut_a) + DW'(7);

    neuron_mac_seq #(
        .N_IN(N_IN), .P(P), .DW(DW), .FRAC(15), .LUT_AW(LUT_AW), .LUT_SHIFT(6)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .mode(mode), .lut_a(lut_a), .lut_q(lut_q),
        .y_valid(y_valid), .y_ready(y_ready), .y(y), .y_sat(y_sat)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model with wide integer arithmetic.
    function automatic void model(input int n, input int ma[16], input int mb[16], input bit md,
                                  output int ey, output int es, output int ea);
        longint acc = 0;
        longint s;
        for (int i = 0; i < n; i++) acc += (longint'(ma[i]) * longint'(mb[i])) >>> 15;
        es = 0;
        ea = -1;
        ey = 0;
        if (!md) begin
            if (acc > 65535) begin ey = 65535; es = 1; end
            else if (acc < -65536) begin ey = -65536; es = 1; end
            else ey = int'(acc);
        end else begin
            s = acc >>> 6;
            if (s > 1023) begin s = 1023; es = 1; end
            else if (s < -1024) begin s = -1024; es = 1; end
            ea = int'(s) + 1024;
            ey = ea + 7;
        end
    endfunction

    // Main monitor: pops on first sight of y_valid, then checks y stays stable.
    exp_t cur;
    bit   have = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            have = 1'b0;
        end else if (y_valid) begin
            if (!have) begin
                if (sb.size() == 0) begin
                    chk("unexpected_y_valid", int'(y_valid), 0);
                end else begin
                    cur  = sb.pop_front();
                    have = 1'b1;
                    chk("y", $signed(y), cur.y);
                    chk("y_sat", int'(y_sat), cur.sat);
                    chk("latency", cyc - cur.acc_cyc, cur.lat);
                    if (cur.addr >= 0) chk("lut_a", int'(lut_a), cur.addr);
                end
            end else begin
                chk("y_stable", $signed(y), cur.y);
            end
            if (y_ready) have = 1'b0;
        end
    end

    task automatic fill(input int xv, input int wv);
        for (int i = 0; i < 8; i++) begin
            xa[i] = xv;
            wa[i] = wv;
        end
    endtask

    task automatic pack();
        for (int i = 0; i < 8; i++) begin
            x[i*DW +: DW] = DW'(xa[i]);
            w[i*DW +: DW] = DW'(wa[i]);
        end
    endtask

    // Called at posedge+1; waits for in_ready, presents one vector for one accept.
    task automatic send(input bit md, input int ey, input int es, input int ea,
                        input int lat, input bit push);
        int k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("send_in_ready", int'(in_ready), 1);
        pack();
        mode     = md;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (push) sb.push_back('{ey, es, ea, lat, cyc});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_in_ready", int'(in_ready), 1);
    endtask

    // Parameter sweep instances: N_IN=16,P=4 and N_IN=8,P=8.
    for (genvar c = 0; c < 2; c++) begin : g_sw
        localparam int SN = (c == 0) ? 16 : 8;
        localparam int SP = (c == 0) ? 4 : 8;
        localparam int SB = SN / SP;

        logic               s_in_valid = 1'b0;
        logic               s_in_ready;
        logic [SN*DW-1:0]   s_x = '0;
        logic [SN*DW-1:0]   s_w = '0;
        logic               s_mode = 1'b0;
        logic [LUT_AW-1:0]  s_lut_a;
        logic [DW-1:0]      s_lut_q;
        logic               s_y_valid;
        logic [DW-1:0]      s_y;
        logic               s_y_sat;
        exp_t               s_sb[$];
        exp_t               s_cur;
        bit                 done = 1'b0;

        always @(posedge clk) s_lut_q <= DW'(s_lut_a) + DW'(7);

        neuron_mac_seq #(
            .N_IN(SN), .P(SP), .DW(DW), .FRAC(15), .LUT_AW(LUT_AW), .LUT_SHIFT(6)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .x(s_x), .w(s_w), .mode(s_mode), .lut_a(s_lut_a), .lut_q(s_lut_q),
            .y_valid(s_y_valid), .y_ready(1'b1), .y(s_y), .y_sat(s_y_sat)
        );

        initial forever begin
            @(negedge clk);
            if (rst_n && s_y_valid) begin
                if (s_sb.size() == 0) begin
                    chk($sformatf("sw%0d_unexpected", c), int'(s_y_valid), 0);
                end else begin
                    s_cur = s_sb.pop_front();
                    chk($sformatf("sw%0d_y", c), $signed(s_y), s_cur.y);
                    chk($sformatf("sw%0d_y_sat", c), int'(s_y_sat), s_cur.sat);
                    chk($sformatf("sw%0d_latency", c), cyc - s_cur.acc_cyc, s_cur.lat);
                    if (s_cur.addr >= 0) chk($sformatf("sw%0d_lut_a", c), int'(s_lut_a), s_cur.addr);
                end
            end
        end

        initial begin
            int sxa[16];
            int swa[16];
            int ey, es, ea, k;
            bit md;
            wait (sweep_go);
            @(posedge clk); #1;
            for (int v = 0; v < 8; v++) begin
                md = ((v % 2) == 1);
                for (int i = 0; i < 16; i++) begin
                    if (v < 4) begin
                        sxa[i] = int'($urandom_range(0, 131071)) - 65536;
                        swa[i] = int'($urandom_range(0, 131071)) - 65536;
                    end else begin
                        sxa[i] = int'($urandom_range(0, 8191)) - 4096;
                        swa[i] = int'($urandom_range(0, 65535)) - 32768;
                    end
                end
                model(SN, sxa, swa, md, ey, es, ea);
                k = 0;
                while (!s_in_ready && k < 100) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk($sformatf("sw%0d_in_ready", c), int'(s_in_ready), 1);
                for (int i = 0; i < SN; i++) begin
                    s_x[i*DW +: DW] = DW'(sxa[i]);
                    s_w[i*DW +: DW] = DW'(swa[i]);
                end
                s_mode     = md;
                s_in_valid = 1'b1;
                @(posedge clk); #1;
                s_sb.push_back('{ey, es, ea, md ? SB + 3 : SB + 1, cyc});
                s_in_valid = 1'b0;
            end
            k = 0;
            while ((s_sb.size() != 0 || !s_in_ready) && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            chk($sformatf("sw%0d_drain", c), s_sb.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int k;

        // Reset held low with random inputs.
        rst_n    = 1'b0;
        y_ready  = 1'b0;
        in_valid = 1'b1;
        mode     = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            x[i*DW +: DW] = DW'($urandom);
            w[i*DW +: DW] = DW'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_y_sat", int'(y_sat), 0);
        chk("rst_lut_a", int'(lut_a), 1024);
        chk("rst_in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        y_ready  = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Linear, exact: x_i = 1000*i at weight 1.0.
        for (int i = 0; i < 8; i++) begin
            xa[i] = 1000 * i;
            wa[i] = 32768;
        end
        send(1'b0, 28000, 0, -1, 5, 1'b1);
        // Linear saturation, both rails.
        fill(16384, 32768);
        send(1'b0, 65535, 1, -1, 5, 1'b1);
        fill(-32768, 32768);
        send(1'b0, -65536, 1, -1, 5, 1'b1);
        // Floor rounding: each (-1*1)>>>15 is -1.
        fill(-1, 1);
        send(1'b0, -8, 0, -1, 5, 1'b1);
        // Sigmoid path.
        fill(0, 0);
        xa[0] = 32768;
        wa[0] = 32768;
        send(1'b1, 1543, 0, 1536, 7, 1'b1);
        fill(0, 0);
        send(1'b1, 1031, 0, 1024, 7, 1'b1);
        fill(16384, 32768);
        send(1'b1, 2054, 1, 2047, 7, 1'b1);
        fill(-32768, 32768);
        send(1'b1, 7, 1, 0, 7, 1'b1);
        drain();

        // Backpressure with a second vector waiting.
        y_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xa[i] = 1000 * i;
            wa[i] = 32768;
        end
        send(1'b0, 28000, 0, -1, 5, 1'b1);
        fill(4096, 16384);
        pack();
        mode     = 1'b0;
        in_valid = 1'b1;
        k = 0;
        while (!y_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("bp_y_valid", int'(y_valid), 1);
        repeat (4) begin
            chk("bp_in_ready_low", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        y_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_y_valid_drop", int'(y_valid), 0);
        chk("bp_in_ready_after_h", int'(in_ready), 1);
        @(posedge clk); #1;
        sb.push_back('{16384, 0, -1, 5, cyc});
        chk("bp_second_taken", int'(in_ready), 0);
        in_valid = 1'b0;
        drain();

        // Reset asserted mid-MAC: outputs clear at once, in-flight result lost.
        fill(1000, 32768);
        send(1'b0, 0, 0, -1, 0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_y", int'(y), 0);
        chk("midrst_y_valid", int'(y_valid), 0);
        chk("midrst_y_sat", int'(y_sat), 0);
        chk("midrst_lut_a", int'(lut_a), 1024);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (y_valid) cnt++;
        end
        chk("midrst_no_output", cnt, 0);

        // Parameter sweep.
        sweep_go = 1'b1;
        k = 0;
        while (!(g_sw[0].done && g_sw[1].done) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("sweep_done", int'(g_sw[0].done && g_sw[1].done), 1);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
